// File: rtl/io_pkg.sv
// Shared state encodings and defaults for the INPR/OUTR device-side I/O controller.
package io_pkg;

  localparam int DEF_DATA_W = 18;

  typedef enum logic {
    I_EMPTY = 1'b0,
    I_FULL  = 1'b1
  } in_state_t;

  typedef enum logic {
    O_IDLE = 1'b0,
    O_SEND = 1'b1
  } out_state_t;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with a combinational head read; a push is visible after one edge.
// A push while full or a pop while empty is ignored.
module io_fifo #(
  parameter int DATA_W     = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [DATA_W-1:0]               push_data,
  input  logic                            pop,
  output logic [DATA_W-1:0]               pop_data,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH):0]     level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (level == LW'(FIFO_DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset: only entries below the level are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/io_port_ctrl.sv
// Device-side INPR/OUTR controller: device word reaches inpr/FGI two edges after accept; OUTR
// word is offered one edge after outr_write. Input backpressure is !full; output holds until dev_out_ready.
module io_port_ctrl
  import io_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           dev_in_data,
  input  logic                        dev_in_valid,
  output logic                        dev_in_ready,
  output logic [DATA_W-1:0]           dev_out_data,
  output logic                        dev_out_valid,
  input  logic                        dev_out_ready,
  output logic [DATA_W-1:0]           inpr,
  output logic                        flg_i,
  input  logic                        inpr_read,
  input  logic [DATA_W-1:0]           outr,
  input  logic                        outr_write,
  output logic                        flg_o,
  input  logic                        glob_ie,
  input  logic                        en_i,
  input  logic                        en_o,
  output logic                        irq,
  output logic [$clog2(FIFO_DEPTH):0] in_level,
  output logic                        out_ovr
);

  in_state_t         in_state_q, in_state_d;
  out_state_t        out_state_q, out_state_d;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              load_inpr;
  logic              latch_out;
  logic              ovr_set;

  assign dev_in_ready = ~fifo_full;

  io_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (dev_in_valid & dev_in_ready),
    .push_data (dev_in_data),
    .pop       (load_inpr),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (in_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_state_q  <= I_EMPTY;
      out_state_q <= O_IDLE;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
    end
  end

  always_comb begin
    in_state_d = in_state_q;
    load_inpr  = 1'b0;
    if (in_state_q == I_EMPTY) begin
      if (!fifo_empty) begin
        load_inpr  = 1'b1;
        in_state_d = I_FULL;
      end
    end else if (inpr_read) begin
      in_state_d = I_EMPTY;
    end
  end

  // A write while a word is still pending is dropped and flagged; it never disturbs dev_out_data.
  always_comb begin
    out_state_d = out_state_q;
    latch_out   = 1'b0;
    ovr_set     = 1'b0;
    if (out_state_q == O_IDLE) begin
      if (outr_write) begin
        latch_out   = 1'b1;
        out_state_d = O_SEND;
      end
    end else begin
      ovr_set = outr_write;
      if (dev_out_ready) out_state_d = O_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inpr         <= '0;
      dev_out_data <= '0;
      out_ovr      <= 1'b0;
    end else begin
      if (load_inpr) inpr         <= fifo_head;
      if (latch_out) dev_out_data <= outr;
      if (ovr_set)   out_ovr      <= 1'b1;
    end
  end

  assign flg_i         = (in_state_q == I_FULL);
  assign flg_o         = (out_state_q == O_IDLE);
  assign dev_out_valid = (out_state_q == O_SEND);
  assign irq           = glob_ie & ((en_i & flg_i) | (en_o & flg_o));

endmodule

// File: tb/tb_io_port_ctrl.sv
// Scoreboarded bench for io_port_ctrl: directed scenarios followed by random traffic and a mid-stream reset.
module tb_io_port_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] dev_in_data = '0;
  logic        dev_in_valid = 1'b0;
  logic        dev_in_ready;
  logic [17:0] dev_out_data;
  logic        dev_out_valid;
  logic        dev_out_ready = 1'b0;
  logic [17:0] inpr;
  logic        flg_i;
  logic        inpr_read = 1'b0;
  logic [17:0] outr = '0;
  logic        outr_write = 1'b0;
  logic        flg_o;
  logic        glob_ie = 1'b1;
  logic        en_i = 1'b0;
  logic        en_o = 1'b1;
  logic        irq;
  logic [2:0]  in_level;
  logic        out_ovr;

  io_port_ctrl #(.DATA_W(18), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .dev_in_data   (dev_in_data),
    .dev_in_valid  (dev_in_valid),
    .dev_in_ready  (dev_in_ready),
    .dev_out_data  (dev_out_data),
    .dev_out_valid (dev_out_valid),
    .dev_out_ready (dev_out_ready),
    .inpr          (inpr),
    .flg_i         (flg_i),
    .inpr_read     (inpr_read),
    .outr          (outr),
    .outr_write    (outr_write),
    .flg_o         (flg_o),
    .glob_ie       (glob_ie),
    .en_i          (en_i),
    .en_o          (en_o),
    .irq           (irq),
    .in_level      (in_level),
    .out_ovr       (out_ovr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: occupancy count, flags and expected-word queues.
  int          m_cnt;
  bit          m_flg_i;
  bit          m_busy;
  bit          m_ovr;
  logic [17:0] exp_in_q[$];
  logic [17:0] exp_out_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_flg_i = 1'b0;
    m_busy  = 1'b0;
    m_ovr   = 1'b0;
    exp_in_q.delete();
    exp_out_q.delete();
  endtask

  task automatic check_reset_vals();
    chk("rst_inpr", 32'(inpr), 0);
    chk("rst_flg_i", 32'(flg_i), 0);
    chk("rst_flg_o", 32'(flg_o), 1);
    chk("rst_out_valid", 32'(dev_out_valid), 0);
    chk("rst_out_data", 32'(dev_out_data), 0);
    chk("rst_in_level", 32'(in_level), 0);
    chk("rst_out_ovr", 32'(out_ovr), 0);
    chk("rst_in_ready", 32'(dev_in_ready), 1);
    chk("rst_irq", 32'(irq), 32'(glob_ie & en_o));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst           = 1'b0;
    dev_in_valid  = 1'b0;
    inpr_read     = 1'b0;
    outr_write    = 1'b0;
    dev_out_ready = 1'b0;
    model_reset();
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Drive one cycle of inputs, then advance the model across the edge that samples them.
  task automatic step(input bit v, input logic [17:0] d, input bit r,
                      input bit w, input logic [17:0] wd, input bit o);
    int  n_pre;
    bit  acc;
    @(negedge clk);
    #1;
    dev_in_valid  = v;
    dev_in_data   = d;
    inpr_read     = r;
    outr_write    = w;
    outr          = wd;
    dev_out_ready = o;
    @(posedge clk);
    n_pre = m_cnt;
    acc   = v && (n_pre < 4);
    if (m_flg_i && r) begin
      m_flg_i = 1'b0;
    end else if (!m_flg_i && n_pre > 0) begin
      m_flg_i = 1'b1;
      m_cnt--;
    end
    if (acc) begin
      m_cnt++;
      exp_in_q.push_back(d);
    end
    if (!m_busy) begin
      if (w) begin
        m_busy = 1'b1;
        exp_out_q.push_back(wd);
      end
    end else begin
      if (w) m_ovr = 1'b1;
      if (o) m_busy = 1'b0;
    end
  endtask

  // Monitor: a new word is presented on each rising flg_i / dev_out_valid.
  bit          prev_fi = 1'b0;
  bit          prev_ov = 1'b0;
  logic [17:0] cur_in  = '0;
  logic [17:0] cur_out = '0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_fi = 1'b0;
      prev_ov = 1'b0;
    end else begin
      if (flg_i && !prev_fi) begin
        chk("in_word_expected", 32'(exp_in_q.size() != 0), 1);
        if (exp_in_q.size() != 0) cur_in = exp_in_q.pop_front();
      end
      if (flg_i) chk("inpr_data", 32'(inpr), 32'(cur_in));
      if (dev_out_valid && !prev_ov) begin
        chk("out_word_expected", 32'(exp_out_q.size() != 0), 1);
        if (exp_out_q.size() != 0) cur_out = exp_out_q.pop_front();
      end
      if (dev_out_valid) chk("out_data", 32'(dev_out_data), 32'(cur_out));
      chk("flg_i", 32'(flg_i), 32'(m_flg_i));
      chk("flg_o", 32'(flg_o), 32'(!m_busy));
      chk("out_valid", 32'(dev_out_valid), 32'(m_busy));
      chk("in_level", 32'(in_level), 32'(m_cnt));
      chk("in_ready", 32'(dev_in_ready), 32'(m_cnt < 4));
      chk("out_ovr", 32'(out_ovr), 32'(m_ovr));
      chk("irq", 32'(irq), 32'(glob_ie & ((en_i & m_flg_i) | (en_o & !m_busy))));
      prev_fi = flg_i;
      prev_ov = dev_out_valid;
    end
  end

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 50 == 0) begin
        glob_ie = 1'($urandom_range(0, 1));
        en_i    = 1'($urandom_range(0, 1));
        en_o    = 1'($urandom_range(0, 1));
      end
      step(1'($urandom_range(0, 1)), 18'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, 18'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    model_reset();
    do_reset();

    // Input stream with a read one cycle after each flg_i rise; irq follows flg_i.
    #1;
    glob_ie = 1'b1; en_i = 1'b1; en_o = 1'b0;
    step(1, 18'h00011, 0, 0, 0, 0);
    step(1, 18'h00022, 0, 0, 0, 0);
    step(1, 18'h00033, 0, 0, 0, 0);
    repeat (10) step(0, 0, m_flg_i, 0, 0, 0);

    // Global enable masks irq while a word is held.
    step(1, 18'h00044, 0, 0, 0, 0);
    #1 glob_ie = 1'b0;
    repeat (3) step(0, 0, 0, 0, 0, 0);
    #1 glob_ie = 1'b1;
    repeat (4) step(0, 0, m_flg_i, 0, 0, 0);

    // FIFO fill with reads held off: sixth word must be refused.
    for (int i = 1; i <= 6; i++) step(1, 18'(32'h100 + i), 0, 0, 0, 0);
    repeat (2) step(1, 18'h3FFFF, 0, 0, 0, 0);
    repeat (14) step(0, 0, m_flg_i, 0, 0, 0);

    // Output backpressure, then an overrun while the word is pending.
    #1 en_i = 1'b0; en_o = 1'b1;
    step(0, 0, 0, 1, 18'h2ABCD, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 18'h00001, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 18'h00777, 1);
    step(0, 0, 0, 0, 0, 1);

    // Random traffic with a reset landing mid-stream.
    random_phase(900);
    do_reset();
    random_phase(900);

    // Drain both paths and confirm nothing expected was left unpresented.
    for (int i = 0; i < 30; i++) step(0, 0, 1, 0, 0, 1);
    @(negedge clk);
    #1;
    chk("in_q_drained", 32'(exp_in_q.size()), 0);
    chk("out_q_drained", 32'(exp_out_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
